// File: rtl/pmem_arbiter.sv
// Arbitrates I-cache and D-cache line fills/writebacks onto one physical memory port.
// Define PMEM_ARB_ROUND_ROBIN_EN to alternate grants under contention (default: fixed D-over-I).
module pmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RECOVER} state_t;

  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-4){1'b1}}, 4'b0000};

  state_t      state, state_next;
  logic        op_write_q;
  logic        last_grant_d;
  logic        d_req;
  logic        prefer_d;
  logic        grant_d;
  logic        grant_i;
  logic [ADDR_W-1:0] addr_sel;

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  // Fixed priority keeps last_grant up to date but never lets it steer the choice.
  always_comb begin
    d_req = d_pmem_read | d_pmem_write;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    prefer_d = ~last_grant_d;
`else
    prefer_d = last_grant_d | 1'b1;
`endif
    if (d_req && i_pmem_read) grant_d = prefer_d;
    else                      grant_d = d_req;
    grant_i  = i_pmem_read & ~grant_d;
    addr_sel = grant_d ? d_pmem_address : i_pmem_address;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Resp is forwarded combinationally so the cache sees it in the same cycle as pmem_resp.
  always_comb begin
    state_next  = state;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    case (state)
      IDLE: begin
        if (grant_d)      state_next = SERVE_D;
        else if (grant_i) state_next = SERVE_I;
      end
      SERVE_I: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          i_pmem_resp = 1'b1;
          state_next  = RECOVER;
        end
      end
      SERVE_D: begin
        pmem_read  = ~op_write_q;
        pmem_write = op_write_q;
        if (pmem_resp) begin
          d_pmem_resp = 1'b1;
          state_next  = RECOVER;
        end
      end
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A simultaneous read+write from the D-cache is latched as a write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pmem_address <= '0;
      pmem_wdata   <= '0;
      op_write_q   <= 1'b0;
      last_grant_d <= 1'b1;
    end else if (state == IDLE && (grant_d || grant_i)) begin
      pmem_address <= addr_sel & LINE_MASK;
      op_write_q   <= grant_d & d_pmem_write;
      last_grant_d <= grant_d;
      if (grant_d && d_pmem_write) pmem_wdata <= d_pmem_wdata;
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios then randomized cache/memory traffic,
// all checked against a transaction-level model of the arbiter.
module tb_pmem_arbiter;

  logic         clk;
  logic         reset_n;
  logic         i_pmem_read;
  logic [15:0]  i_pmem_address;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [15:0]  d_pmem_address;
  logic [127:0] d_pmem_wdata;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  pmem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: one transaction in flight, the arbiter is free again two cycles after its resp.
  logic         m_busy, m_who_d, m_write, m_last_d;
  logic [15:0]  m_addr;
  logic [127:0] m_wdata;
  int           m_free;
  int           cyc = 0;
  logic         obs_ir, obs_dr, obs_req;
  int           d_grants, i_grants;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic modelReset();
    m_busy   = 1'b0;
    m_who_d  = 1'b0;
    m_write  = 1'b0;
    m_last_d = 1'b1;
    m_addr   = '0;
    m_wdata  = '0;
    m_free   = cyc;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Compares one cycle at the falling edge, then advances the model to the next cycle.
  task automatic tick();
    logic exp_rd, exp_wr, exp_ir, exp_dr, d_req, i_req, take_d;
    @(negedge clk);
    if (!reset_n) modelReset();
    exp_rd = m_busy & ~m_write;
    exp_wr = m_busy & m_write;
    exp_ir = m_busy & ~m_who_d & pmem_resp & reset_n;
    exp_dr = m_busy & m_who_d & pmem_resp & reset_n;
    checkOutput("pmem_read", 128'(pmem_read), 128'(exp_rd));
    checkOutput("pmem_write", 128'(pmem_write), 128'(exp_wr));
    checkOutput("i_resp", 128'(i_pmem_resp), 128'(exp_ir));
    checkOutput("d_resp", 128'(d_pmem_resp), 128'(exp_dr));
    checkOutput("pmem_address", 128'(pmem_address), 128'(m_addr));
    checkOutput("pmem_wdata", pmem_wdata, m_wdata);
    checkOutput("i_rdata", i_pmem_rdata, pmem_rdata);
    checkOutput("d_rdata", d_pmem_rdata, pmem_rdata);
    obs_ir  = i_pmem_resp;
    obs_dr  = d_pmem_resp;
    obs_req = pmem_read | pmem_write;
    if (reset_n) begin
      if (m_busy) begin
        if (pmem_resp) begin
          m_busy = 1'b0;
          m_free = cyc + 2;
        end
      end else if (cyc >= m_free) begin
        d_req = d_pmem_read | d_pmem_write;
        i_req = i_pmem_read;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
        take_d = d_req & (~i_req | ~m_last_d);
`else
        take_d = d_req;
`endif
        if (d_req || i_req) begin
          m_busy   = 1'b1;
          m_who_d  = take_d;
          m_last_d = take_d;
          m_addr   = (take_d ? d_pmem_address : i_pmem_address) & 16'hFFF0;
          m_write  = take_d & d_pmem_write;
          if (m_write) m_wdata = d_pmem_wdata;
          if (take_d) d_grants++; else i_grants++;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int cycles);
    int mem_wait = -1;
    for (int n = 0; n < cycles; n++) begin
      pmem_rdata = rand128();
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        mem_wait  = -1;
      end else if (obs_req) begin
        if (mem_wait < 0) mem_wait = int'($urandom_range(0, 3));
        if (mem_wait == 0) begin
          pmem_resp = 1'b1;
          mem_wait  = -1;
        end else mem_wait--;
      end else pmem_resp = ($urandom_range(0, 15) == 0);
      if (obs_ir) i_pmem_read = 1'b0;
      else if (!i_pmem_read && $urandom_range(0, 2) == 0) begin
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'($urandom);
      end
      if (i_pmem_read && $urandom_range(0, 7) == 0) i_pmem_address = 16'($urandom);
      if (obs_dr) begin
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
      end else if (!d_pmem_read && !d_pmem_write && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: d_pmem_read = 1'b1;
          9: begin d_pmem_read = 1'b1; d_pmem_write = 1'b1; end
          default: d_pmem_write = 1'b1;
        endcase
        d_pmem_address = 16'($urandom);
      end
      if ($urandom_range(0, 3) == 0) d_pmem_wdata = rand128();
      tick();
    end
  endtask

  initial begin
    logic [127:0] line;
    reset_n = 1'b1;
    i_pmem_read = 0; i_pmem_address = 0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = 0; d_pmem_wdata = 0;
    pmem_rdata = 0; pmem_resp = 0;
    d_grants = 0; i_grants = 0;
    modelReset();
    #3 reset_n = 1'b0;
    #1;
    checkOutput("rst_read", 128'(pmem_read), 128'd0);
    checkOutput("rst_write", 128'(pmem_write), 128'd0);
    checkOutput("rst_addr", 128'(pmem_address), 128'd0);
    checkOutput("rst_wdata", pmem_wdata, 128'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Single I-fill with resp after 5 cycles.
    i_pmem_read = 1'b1; i_pmem_address = 16'h1234;
    tick();
    checkOutput("ifill_read", 128'(pmem_read), 128'd1);
    checkOutput("ifill_addr", 128'(pmem_address), 128'h1230);
    i_pmem_address = 16'hFFFF;
    repeat (4) tick();
    line = rand128();
    pmem_resp = 1'b1; pmem_rdata = line;
    #1;
    checkOutput("ifill_iresp", 128'(i_pmem_resp), 128'd1);
    checkOutput("ifill_dresp", 128'(d_pmem_resp), 128'd0);
    checkOutput("ifill_rdata", i_pmem_rdata, line);
    tick();
    pmem_resp = 1'b0; i_pmem_read = 1'b0;
    #1 checkOutput("ifill_pulse", 128'(i_pmem_resp), 128'd0);
    tick(); tick();

    // D writeback; inputs disturbed after grant.
    d_pmem_write = 1'b1; d_pmem_address = 16'h4A7F;
    d_pmem_wdata = 128'hDEADBEEF_01234567_89ABCDEF_CAFEBEEF;
    tick();
    d_pmem_address = 16'h0000; d_pmem_wdata = rand128();
    tick();
    checkOutput("dwb_write", 128'(pmem_write), 128'd1);
    checkOutput("dwb_addr", 128'(pmem_address), 128'h4A70);
    checkOutput("dwb_wdata", pmem_wdata, 128'hDEADBEEF_01234567_89ABCDEF_CAFEBEEF);
    pmem_resp = 1'b1; tick();
    pmem_resp = 1'b0; d_pmem_write = 1'b0;
    tick(); tick();

    // Simultaneous I and D reads; last grant was D.
    i_pmem_read = 1'b1; i_pmem_address = 16'h1111;
    d_pmem_read = 1'b1; d_pmem_address = 16'h2222;
    tick();
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    checkOutput("sim_first", 128'(pmem_address), 128'h1110);
`else
    checkOutput("sim_first", 128'(pmem_address), 128'h2220);
`endif
    pmem_resp = 1'b1; tick();
    pmem_resp = 1'b0;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    i_pmem_read = 1'b0;
`else
    d_pmem_read = 1'b0;
`endif
    tick();
    checkOutput("sim_gap", 128'(pmem_read), 128'd0);
    tick();
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    checkOutput("sim_second", 128'(pmem_address), 128'h2220);
`else
    checkOutput("sim_second", 128'(pmem_address), 128'h1110);
`endif
    checkOutput("sim_second_rd", 128'(pmem_read), 128'd1);
    pmem_resp = 1'b1; tick();
    pmem_resp = 1'b0; i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    tick(); tick();

    // Illegal read+write becomes a write; stray resp in RECOVER is dropped.
    d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 16'h0ABC;
    tick();
    checkOutput("rw_write", 128'(pmem_write), 128'd1);
    checkOutput("rw_read", 128'(pmem_read), 128'd0);
    pmem_resp = 1'b1; tick();
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    #1 checkOutput("stray_dresp", 128'(d_pmem_resp), 128'd0);
    tick();
    pmem_resp = 1'b0;
    tick();

    // Reset during SERVE_D with resp in the same cycle.
    d_pmem_write = 1'b1; d_pmem_address = 16'h5555; d_pmem_wdata = rand128();
    tick();
    pmem_resp = 1'b1;
    #1 checkOutput("pre_rst_dresp", 128'(d_pmem_resp), 128'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_write", 128'(pmem_write), 128'd0);
    checkOutput("rst_mid_dresp", 128'(d_pmem_resp), 128'd0);
    modelReset();
    d_pmem_write = 1'b0;
    tick();
    pmem_resp = 1'b0; reset_n = 1'b1;
    i_pmem_read = 1'b1; i_pmem_address = 16'h7777;
    tick();
    checkOutput("post_rst_grant", 128'(pmem_read), 128'd1);
    pmem_resp = 1'b1; tick();
    pmem_resp = 1'b0; i_pmem_read = 1'b0;
    tick(); tick();

    applyStimulus(4000);
    total++;
    if (d_grants == 0 || i_grants == 0) begin
      bad++;
      $display("[TB] FAIL grant_mix: d=%0d i=%0d want both nonzero", d_grants, i_grants);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
